// File: rtl/jtag_xfer_sched.sv
// jtag_xfer_sched: arbitrates NREQ JTAG scan requesters onto a single PHY
// command/response FIFO pair, one transaction in flight at a time.
// Optional IR cache: define JTAG_XFER_SCHED_IRCACHE_EN to skip re-sending an
// instruction that matches the last IR shifted into the TAP.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | nothing pending
// S_ARB     | round-robin pick, latch the winner's request fields
// S_SEND_IR | push IR packet when the command FIFO has room
// S_SEND_DR | push DR packet (or TAP-reset packet for DRLEN=0)
// S_RD_WAIT | wait for the PHY response, pop it
// S_RD_CAP  | response data on RDDATA, right-justify into RSP_DATA
// S_DONE    | REQ_DONE visible for one cycle, re-arbitrate or idle
module jtag_xfer_sched #(
  parameter int NREQ     = 2,
  parameter int IR_LEN   = 8,
  parameter int BUF_SZ   = 64,
  parameter int MAX_CLEN = 4096,
  localparam int LW = $clog2(MAX_CLEN),
  localparam int BW = $clog2(BUF_SZ),
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ-1:0]           REQ_READ,
  input  logic [NREQ*IR_LEN-1:0]    REQ_IR,
  input  logic [NREQ*BUF_SZ-1:0]    REQ_DR,
  input  logic [NREQ*(BW+1)-1:0]    REQ_DRLEN,
  output logic [NREQ-1:0]           REQ_DONE,
  output logic [BUF_SZ-1:0]         RSP_DATA,
  output logic                      RSP_VALID,
  output logic [IW-1:0]             RSP_ID,
  output logic [BUF_SZ+3+LW-1:0]    WRDATA,
  output logic                      WREN,
  input  logic                      WRFULL,
  input  logic [BUF_SZ+BW-1:0]      RDDATA,
  output logic                      RDEN,
  input  logic                      RDEMPTY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SEND_IR, S_SEND_DR, S_RD_WAIT, S_RD_CAP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]     last_grant_q, grant_q, arb_idx;
  logic              arb_found;
  logic [IW:0]       cand;
  logic              any_valid;

  logic              sel_read;
  logic [IR_LEN-1:0] sel_ir;
  logic [BUF_SZ-1:0] sel_dr;
  logic [BW:0]       sel_drlen;

  logic              lat_read;
  logic [IR_LEN-1:0] lat_ir;
  logic [BUF_SZ-1:0] lat_dr;
  logic [BW:0]       lat_drlen;

  logic              ir_hit;
  logic [NREQ-1:0]   grant_onehot;
  logic [BW:0]       rsp_shift;
  logic [BUF_SZ-1:0] rd_data;
  logic [BUF_SZ-1:0] rsp_next;
  logic              rd_ilen_unused;

  assign any_valid      = |REQ_VALID;
  assign rd_data        = RDDATA[BUF_SZ+BW-1:BW];
  assign rd_ilen_unused = ^RDDATA[BW-1:0];
  // a read of DRLEN bits lands in the top of the PHY word
  assign rsp_shift      = (BW+1)'(BUF_SZ) - lat_drlen;
  assign rsp_next       = rd_data >> rsp_shift;

  // round-robin: first valid requester after the last grant, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!arb_found && REQ_VALID[cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IW-1:0];
      end
    end
  end

  // mux the arbitration winner's request fields
  always_comb begin
    sel_read  = 1'b0;
    sel_ir    = '0;
    sel_dr    = '0;
    sel_drlen = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_read  = REQ_READ[i];
        sel_ir    = REQ_IR[i*IR_LEN +: IR_LEN];
        sel_dr    = REQ_DR[i*BUF_SZ +: BUF_SZ];
        sel_drlen = REQ_DRLEN[i*(BW+1) +: (BW+1)];
      end
    end
  end

  // one-hot completion vector for the current owner
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) grant_onehot[i] = (grant_q == IW'(i));
  end

`ifdef JTAG_XFER_SCHED_IRCACHE_EN
  logic [IR_LEN-1:0] ir_cache_q;
  logic              ir_cache_vld_q;

  // remember the IR in the TAP; a TAP reset packet forgets it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir_cache_q     <= '0;
      ir_cache_vld_q <= 1'b0;
    end else if (WREN && state_q == S_SEND_IR) begin
      ir_cache_q     <= lat_ir;
      ir_cache_vld_q <= 1'b1;
    end else if (WREN && state_q == S_SEND_DR && lat_drlen == '0) begin
      ir_cache_vld_q <= 1'b0;
    end
  end

  assign ir_hit = ir_cache_vld_q && (sel_ir == ir_cache_q);
`else
  assign ir_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_valid) state_d = S_ARB;
      S_ARB: begin
        if (!arb_found)                         state_d = S_IDLE;
        else if (sel_drlen == '0 || ir_hit)     state_d = S_SEND_DR;
        else                                    state_d = S_SEND_IR;
      end
      S_SEND_IR: if (!WRFULL) state_d = S_SEND_DR;
      S_SEND_DR: begin
        if (!WRFULL) state_d = (lat_read && lat_drlen != '0) ? S_RD_WAIT : S_DONE;
      end
      S_RD_WAIT: if (!RDEMPTY) state_d = S_RD_CAP;
      S_RD_CAP:  state_d = S_DONE;
      S_DONE:    state_d = any_valid ? S_ARB : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // PHY FIFO strobes and command packet; zero outside the send states
  always_comb begin
    WREN   = 1'b0;
    RDEN   = 1'b0;
    WRDATA = '0;
    case (state_q)
      S_SEND_IR: begin
        WREN   = !WRFULL;
        WRDATA = {BUF_SZ'(lat_ir), LW'(IR_LEN), 3'b100};
      end
      S_SEND_DR: begin
        WREN = !WRFULL;
        if (lat_drlen == '0) WRDATA = '0;
        else WRDATA = {lat_dr, LW'(lat_drlen), lat_read ? 3'b001 : 3'b000};
      end
      S_RD_WAIT: RDEN = !RDEMPTY;
      default: ;
    endcase
  end

  // grant and request fields are frozen at arbitration until DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_q      <= '0;
      last_grant_q <= IW'(NREQ-1);
      lat_read     <= 1'b0;
      lat_ir       <= '0;
      lat_dr       <= '0;
      lat_drlen    <= '0;
    end else if (state_q == S_ARB && arb_found) begin
      grant_q      <= arb_idx;
      last_grant_q <= arb_idx;
      lat_read     <= sel_read;
      lat_ir       <= sel_ir;
      lat_dr       <= sel_dr;
      lat_drlen    <= sel_drlen;
    end
  end

  // registered completion and response strobes, both visible in S_DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      REQ_DONE  <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ID    <= '0;
    end else begin
      REQ_DONE  <= (state_d == S_DONE) ? grant_onehot : '0;
      RSP_VALID <= (state_q == S_RD_CAP);
      if (state_q == S_RD_CAP) begin
        RSP_DATA <= rsp_next;
        RSP_ID   <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_jtag_xfer_sched.sv
// Bench for jtag_xfer_sched: behavioural PHY FIFOs plus a packet/response
// scoreboard. Expectations honour JTAG_XFER_SCHED_IRCACHE_EN when defined.
module tb_jtag_xfer_sched;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [1:0]    REQ_VALID, REQ_READ;
  logic [15:0]   REQ_IR;
  logic [127:0]  REQ_DR;
  logic [13:0]   REQ_DRLEN;
  logic [1:0]    REQ_DONE;
  logic [63:0]   RSP_DATA;
  logic          RSP_VALID;
  logic [0:0]    RSP_ID;
  logic [78:0]   WRDATA;
  logic          WREN;
  logic          WRFULL;
  logic [69:0]   RDDATA = '0;
  logic          RDEN;
  logic          RDEMPTY = 1'b1;

  jtag_xfer_sched dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READ(REQ_READ), .REQ_IR(REQ_IR),
    .REQ_DR(REQ_DR), .REQ_DRLEN(REQ_DRLEN), .REQ_DONE(REQ_DONE),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
    .WRDATA(WRDATA), .WREN(WREN), .WRFULL(WRFULL),
    .RDDATA(RDDATA), .RDEN(RDEN), .RDEMPTY(RDEMPTY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  done;
    logic        rv;
    logic [0:0]  id;
    logic [63:0] data;
  } ev_t;

  ev_t         ev_q[$];
  ev_t         mon_e;
  logic [78:0] pkt_q[$];
  logic [78:0] exp_q[$];
  logic [69:0] rq[$];
  int          rden_cnt = 0, wren_cnt = 0, rv_cnt = 0;
  int          n_checks = 0, n_pass = 0;
  logic [7:0]  m_ir = '0;
  bit          m_vld = 1'b0;

  // monitor plus PHY response FIFO pop; sampled mid-cycle
  always @(negedge CLK) begin
    if (WREN) begin pkt_q.push_back(WRDATA); wren_cnt++; end
    if (RDEN) begin
      rden_cnt++;
      if (rq.size() > 0) RDDATA = rq.pop_front();
    end
    if (RSP_VALID) rv_cnt++;
    if (REQ_DONE != 2'b00) begin
      mon_e.done = REQ_DONE; mon_e.rv = RSP_VALID;
      mon_e.id = RSP_ID; mon_e.data = RSP_DATA;
      ev_q.push_back(mon_e);
    end
  end

  always @(posedge CLK) begin
    #1;
    RDEMPTY = (rq.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic set_req(input int i, input bit rd, input logic [7:0] ir,
                         input logic [63:0] dr, input logic [6:0] len);
    REQ_READ[i] = rd;
    REQ_IR[i*8 +: 8] = ir;
    REQ_DR[i*64 +: 64] = dr;
    REQ_DRLEN[i*7 +: 7] = len;
  endtask

  // reference packets a request should produce on the command FIFO
  task automatic exp_xfer(input logic [7:0] ir, input logic [63:0] dr,
                          input logic [6:0] len, input bit rd);
    bit skip;
    if (len == 7'd0) begin
      exp_q.push_back(79'd0);
      m_vld = 1'b0;
    end else begin
      skip = 1'b0;
`ifdef JTAG_XFER_SCHED_IRCACHE_EN
      skip = m_vld && (m_ir == ir);
`endif
      if (!skip) exp_q.push_back({56'd0, ir, 12'd8, 3'b100});
      m_ir = ir; m_vld = 1'b1;
      exp_q.push_back({dr, 5'd0, len, rd ? 3'b001 : 3'b000});
    end
  endtask

  task automatic wait_done(output ev_t e, output bit ok);
    ok = 1'b0;
    e.done = '0; e.rv = 1'b0; e.id = '0; e.data = '0;
    for (int c = 0; c < 200; c++) begin
      tick(1);
      if (ev_q.size() > 0) begin e = ev_q.pop_front(); ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pkts(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick(1);
      if (pkt_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; REQ_VALID = '0; REQ_READ = '0; REQ_IR = '0; REQ_DR = '0;
    REQ_DRLEN = '0; WRFULL = 1'b0;
    tick(3);
    n_checks++; if (WREN !== 1'b0) $display("FAIL reset_wren: got %b required 0", WREN); else n_pass++;
    n_checks++; if (RDEN !== 1'b0) $display("FAIL reset_rden: got %b required 0", RDEN); else n_pass++;
    n_checks++; if (RSP_VALID !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", RSP_VALID); else n_pass++;
    n_checks++; if (REQ_DONE !== 2'b00) $display("FAIL reset_req_done: got %b required 00", REQ_DONE); else n_pass++;
    n_checks++; if (RSP_DATA !== 64'd0) $display("FAIL reset_rsp_data: got %h required 0", RSP_DATA); else n_pass++;
    n_checks++; if (WRDATA !== 79'd0) $display("FAIL reset_wrdata: got %h required 0", WRDATA); else n_pass++;
    RESET = 1'b0;
    tick(2);
  endtask

  task automatic test_write;
    ev_t e; bit ok; int r0; logic [78:0] ex, ob;
    r0 = rden_cnt;
    set_req(0, 1'b0, 8'h0A, 64'h1234, 7'd16);
    exp_xfer(8'h0A, 64'h1234, 7'd16, 1'b0);
    REQ_VALID[0] = 1'b1;
    wait_done(e, ok);
    REQ_VALID[0] = 1'b0;
    n_checks++; if (!ok) $display("FAIL write_done_timeout: got none required REQ_DONE"); else n_pass++;
    n_checks++; if (e.done !== 2'b01) $display("FAIL write_done_vec: got %b required 01", e.done); else n_pass++;
    n_checks++; if (e.rv !== 1'b0) $display("FAIL write_rsp_valid: got %b required 0", e.rv); else n_pass++;
    tick(3);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL write_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL write_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
    n_checks++; if (pkt_q.size() != 0) $display("FAIL write_extra_pkts: got %0d required 0", pkt_q.size()); else n_pass++;
    n_checks++; if (rden_cnt != r0) $display("FAIL write_rden: got %0d required 0", rden_cnt - r0); else n_pass++;
  endtask

  task automatic test_read;
    ev_t e; bit ok; int r0, v0, n; logic [78:0] ex, ob; logic [63:0] word, rexp;
    r0 = rden_cnt; v0 = rv_cnt;
    set_req(1, 1'b1, 8'h55, 64'hCAFEF00D, 7'd32);
    exp_xfer(8'h55, 64'hCAFEF00D, 7'd32, 1'b1);
    n = exp_q.size();
    REQ_VALID[1] = 1'b1;
    wait_pkts(n, ok);
    n_checks++; if (!ok) $display("FAIL read_pkt_timeout: got %0d required %0d", pkt_q.size(), n); else n_pass++;
    tick(3);
    word = 64'hDEADBEEF_12345678;
    rexp = word >> (64 - 32);
    rq.push_back({word, 6'd32});
    wait_done(e, ok);
    REQ_VALID[1] = 1'b0;
    n_checks++; if (!ok) $display("FAIL read_done_timeout: got none required REQ_DONE"); else n_pass++;
    n_checks++; if (e.done !== 2'b10) $display("FAIL read_done_vec: got %b required 10", e.done); else n_pass++;
    n_checks++; if (e.rv !== 1'b1) $display("FAIL read_rsp_with_done: got %b required 1", e.rv); else n_pass++;
    n_checks++; if (e.id !== 1'b1) $display("FAIL read_rsp_id: got %0d required 1", e.id); else n_pass++;
    n_checks++; if (e.data !== rexp) $display("FAIL read_rsp_data: got %h required %h", e.data, rexp); else n_pass++;
    tick(3);
    n_checks++; if (rden_cnt - r0 != 1) $display("FAIL read_rden_count: got %0d required 1", rden_cnt - r0); else n_pass++;
    n_checks++; if (rv_cnt - v0 != 1) $display("FAIL read_rsp_count: got %0d required 1", rv_cnt - v0); else n_pass++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL read_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL read_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin;
    ev_t e; bit ok; logic [78:0] ex, ob; logic [1:0] want;
    set_req(0, 1'b0, 8'h11, 64'hAA, 7'd8);
    set_req(1, 1'b0, 8'h22, 64'hBBB, 7'd12);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_xfer(8'h11, 64'hAA, 7'd8, 1'b0);
      else            exp_xfer(8'h22, 64'hBBB, 7'd12, 1'b0);
    end
    REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_done(e, ok);
      n_checks++;
      if (!ok) $display("FAIL rr_done_timeout: got none required grant %0d", k);
      else if (e.done !== want) $display("FAIL rr_grant_order: got %b required %b at %0d", e.done, want, k);
      else n_pass++;
    end
    REQ_VALID = 2'b00;
    tick(3);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL rr_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL rr_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
    n_checks++; if (ev_q.size() != 0) $display("FAIL rr_extra_done: got %0d required 0", ev_q.size()); else n_pass++;
  endtask

  task automatic test_wrfull;
    ev_t e; bit ok; int w0; logic [78:0] ex, ob;
    set_req(0, 1'b0, 8'h33, 64'h5A5A, 7'd16);
    exp_xfer(8'h33, 64'h5A5A, 7'd16, 1'b0);
    REQ_VALID[0] = 1'b1;
    wait_pkts(1, ok);
    WRFULL = 1'b1;
    w0 = wren_cnt;
    n_checks++; if (!ok) $display("FAIL wrfull_ir_timeout: got no IR packet required 1"); else n_pass++;
    tick(10);
    n_checks++; if (wren_cnt != w0) $display("FAIL wrfull_wren_low: got %0d writes required 0", wren_cnt - w0); else n_pass++;
    n_checks++; if (ev_q.size() != 0) $display("FAIL wrfull_early_done: got %0d required 0", ev_q.size()); else n_pass++;
    WRFULL = 1'b0;
    wait_done(e, ok);
    REQ_VALID[0] = 1'b0;
    n_checks++; if (!ok || e.done !== 2'b01) $display("FAIL wrfull_done: got %b required 01", e.done); else n_pass++;
    tick(3);
    n_checks++; if (wren_cnt - w0 != 1) $display("FAIL wrfull_dr_once: got %0d required 1", wren_cnt - w0); else n_pass++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL wrfull_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL wrfull_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
  endtask

  task automatic test_ircache;
    ev_t e; bit ok; int w0, r0; logic [78:0] ex, ob;
    int ncnt[4];
    logic [6:0] lens[4];
`ifdef JTAG_XFER_SCHED_IRCACHE_EN
    ncnt = '{2, 1, 1, 2};
`else
    ncnt = '{2, 2, 1, 2};
`endif
    lens = '{7'd8, 7'd8, 7'd0, 7'd8};
    r0 = rden_cnt;
    for (int t = 0; t < 4; t++) begin
      set_req(0, (t == 2), 8'h0A, 64'hA5, lens[t]);
      exp_xfer(8'h0A, 64'hA5, lens[t], (t == 2));
      w0 = wren_cnt;
      REQ_VALID[0] = 1'b1;
      wait_done(e, ok);
      REQ_VALID[0] = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL ircache_done_timeout: got none required done at %0d", t);
      else if (wren_cnt - w0 != ncnt[t]) $display("FAIL ircache_pkt_count: got %0d required %0d at %0d", wren_cnt - w0, ncnt[t], t);
      else n_pass++;
      tick(2);
    end
    n_checks++; if (rden_cnt != r0) $display("FAIL tapreset_rden: got %0d required 0", rden_cnt - r0); else n_pass++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL ircache_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL ircache_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
  endtask

  task automatic test_stray_rsp;
    int r0;
    r0 = rden_cnt;
    rq.push_back({64'h1, 6'd1});
    tick(8);
    n_checks++; if (rden_cnt != r0) $display("FAIL stray_rsp_rden: got %0d required 0", rden_cnt - r0); else n_pass++;
    rq.delete();
    tick(2);
  endtask

  task automatic test_reset_rd_wait;
    ev_t e; bit ok; int n; logic [78:0] ex, ob;
    set_req(1, 1'b1, 8'h77, 64'h1, 7'd4);
    exp_xfer(8'h77, 64'h1, 7'd4, 1'b1);
    n = exp_q.size();
    REQ_VALID[1] = 1'b1;
    wait_pkts(n, ok);
    n_checks++; if (!ok) $display("FAIL rst_pkt_timeout: got %0d required %0d", pkt_q.size(), n); else n_pass++;
    tick(2);
    #2 RESET = 1'b1;
    #1;
    m_vld = 1'b0;
    n_checks++; if (WREN !== 1'b0 || RDEN !== 1'b0) $display("FAIL rst_async_strobes: got wren=%b rden=%b required 0", WREN, RDEN); else n_pass++;
    n_checks++; if (RSP_VALID !== 1'b0 || REQ_DONE !== 2'b00) $display("FAIL rst_async_done: got rv=%b done=%b required 0", RSP_VALID, REQ_DONE); else n_pass++;
    n_checks++; if (RSP_DATA !== 64'd0) $display("FAIL rst_async_rsp_data: got %h required 0", RSP_DATA); else n_pass++;
    n_checks++; if (RSP_ID !== 1'b0) $display("FAIL rst_async_rsp_id: got %0d required 0", RSP_ID); else n_pass++;
    n_checks++; if (WRDATA !== 79'd0) $display("FAIL rst_async_wrdata: got %h required 0", WRDATA); else n_pass++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL rst_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL rst_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
    set_req(0, 1'b0, 8'h44, 64'h9, 7'd4);
    set_req(1, 1'b0, 8'h66, 64'h3, 7'd4);
    exp_xfer(8'h44, 64'h9, 7'd4, 1'b0);
    exp_xfer(8'h66, 64'h3, 7'd4, 1'b0);
    REQ_VALID = 2'b11;
    @(posedge CLK); #1;
    RESET = 1'b0;
    wait_done(e, ok);
    REQ_VALID[0] = 1'b0;
    n_checks++; if (!ok || e.done !== 2'b01) $display("FAIL rst_first_grant: got %b required 01", e.done); else n_pass++;
    wait_done(e, ok);
    REQ_VALID[1] = 1'b0;
    n_checks++; if (!ok || e.done !== 2'b10) $display("FAIL rst_second_grant: got %b required 10", e.done); else n_pass++;
    tick(3);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if (pkt_q.size() == 0) $display("FAIL rst_after_pkt: got none required %h", ex);
      else begin
        ob = pkt_q.pop_front();
        if (ob !== ex) $display("FAIL rst_after_pkt: got %h required %h", ob, ex); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_wrfull();
    test_ircache();
    test_stray_rsp();
    test_reset_rd_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_xfer_sched.md
JTAG_XFER_SCHED -- requirements
Module: jtag_xfer_sched

Interface
REQ-001 SHALL have parameters: NREQ, default 2, number of requesters.
REQ-002 SHALL have parameters: IR_LEN, default 8, instruction register bits per request.
REQ-003 SHALL have parameters: BUF_SZ, default 64, max DR bits per request; equals PHY packet data width.
REQ-004 SHALL have parameters: MAX_CLEN, default 4096, PHY length field range; LW = $clog2(MAX_CLEN), BW = $clog2(BUF_SZ).
REQ-005 SHALL have ports: CLK  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have ports: RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: REQ_VALID  in  NREQ  request pending, held until REQ_DONE.
REQ-008 SHALL have ports: REQ_READ  in  NREQ  1 = capture DR output.
REQ-009 SHALL have ports: REQ_IR  in  NREQ*IR_LEN  instruction, LSB shifted first.
REQ-010 SHALL have ports: REQ_DR  in  NREQ*BUF_SZ  DR data, LSB first.
REQ-011 SHALL have ports: REQ_DRLEN  in  NREQ*(BW+1)  DR length, 0..BUF_SZ.
REQ-012 SHALL have ports: REQ_DONE  out  NREQ  one-cycle completion pulse.
REQ-013 SHALL have ports: RSP_DATA  out  BUF_SZ  right-justified read data.
REQ-014 SHALL have ports: RSP_VALID  out  1, RSP_ID out $clog2(NREQ)  response strobe / owner.
REQ-015 SHALL have ports: WRDATA out BUF_SZ+3+LW {data,len,cmd}; WREN out 1; WRFULL in 1  PHY command FIFO.
REQ-016 SHALL have ports: RDDATA in BUF_SZ+BW {data,ilen}; RDEN out 1; RDEMPTY in 1  PHY response FIFO.

Function
REQ-017 SHALL implement states IDLE, ARB, SEND_IR, SEND_DR, RD_WAIT, RD_CAP, DONE.
REQ-018 SHALL in ARB grant round-robin: first REQ_VALID after last grant index, wrapping; after reset the last-grant pointer is NREQ-1, so requester 0 wins first.
REQ-019 SHALL latch the granted request's fields in ARB; grant and fields hold until DONE, and later changes on REQ_* are ignored.
REQ-020 SHALL in SEND_IR write one packet {IR zero-extended to BUF_SZ, len=IR_LEN, cmd=3'b100}.
REQ-021 SHALL in SEND_DR write {DR, len=DRLEN, cmd=REQ_READ ? 3'b001 : 3'b000}.
REQ-022 SHALL assert WREN only when WRFULL=0, for exactly one cycle per packet; the state advances in the same cycle WREN is asserted.
REQ-023 SHALL, for DRLEN=0, skip SEND_IR and send one packet with len=0 and cmd=000 (TAP reset), ignoring REQ_READ.
REQ-024 SHALL go from SEND_DR to DONE for write-only requests, and to RD_WAIT for reads.
REQ-025 SHALL in RD_WAIT assert RDEN for one cycle when RDEMPTY=0, then go to RD_CAP; RDDATA is valid the cycle after RDEN.
REQ-026 SHALL in RD_CAP register RSP_DATA = RDDATA data field >> (BUF_SZ-DRLEN), upper bits zero, and assert RSP_VALID with RSP_ID for one cycle, coincident with REQ_DONE.
REQ-027 SHALL in DONE pulse REQ_DONE[grant] for one cycle (reads: same cycle as RSP_VALID), then return to IDLE, or to ARB if any REQ_VALID is set.
REQ-028 SHALL never have more than one transaction outstanding in the PHY; RDEN is never asserted outside RD_WAIT.
REQ-029 SHALL discard a response arriving outside RD_WAIT, and leave RDEN low when that happens.

Reset
REQ-030 SHALL, on RESET=1 at any time, including mid-transaction, set: state IDLE; WREN, RDEN, RSP_VALID, REQ_DONE = 0; RSP_DATA = 0; RSP_ID = 0; last-grant = NREQ-1; IR cache invalid.
REQ-031 SHALL NOT flush the PHY FIFOs on reset; those have their own reset.

Configuration
REQ-032 SHALL support macro JTAG_XFER_SCHED_IRCACHE_EN. When defined: hold the last IR sent plus a valid bit; skip SEND_IR when the granted IR equals the cached IR and the cache is valid; a DRLEN=0 packet or RESET invalidates the cache. When undefined: always send the IR packet, and generate no cache registers.

Verification
REQ-033 SHALL cover: req0 write IR=0x0A, DR=0x1234, DRLEN=16 -> packets {0x0A,8,100} then {0x1234,16,000}; REQ_DONE[0] pulses; RDEN never asserted.
REQ-034 SHALL cover: req1 read DRLEN=32, PHY returns data 0xDEADBEEF in bits [63:32] -> RSP_DATA=0x00000000DEADBEEF, RSP_ID=1, RSP_VALID and REQ_DONE[1] on the same cycle.
REQ-035 SHALL cover: REQ_VALID=2'b11 held for 4 transactions -> grant order 0,1,0,1.
REQ-036 SHALL cover: WRFULL=1 for 10 cycles during SEND_DR -> WREN stays low; the packet is written once after WRFULL falls.
REQ-037 SHALL cover: with IRCACHE_EN, two requests with IR=0x0A -> second issues only the DR packet; a DRLEN=0 request in between -> IR is resent. Without IRCACHE_EN -> IR is always sent.
REQ-038 SHALL cover: RESET asserted in RD_WAIT -> all outputs 0 asynchronously; the next grant goes to requester 0.
